imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the instruction memory word-address width (1024 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port rx_valid, input, 1, meaning an rx_data byte is offered this cycle.
REQ-006 SHALL have port rx_data, input, 8, the serial-link byte.
REQ-007 SHALL have port rx_ready, output, 1, meaning a byte is accepted when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port imem_we, output, 1, the instruction memory write enable.
REQ-009 SHALL have port imem_addr, output, ADDR_WIDTH, the instruction memory word address.
REQ-010 SHALL have port imem_wdata, output, DATA_WIDTH, the instruction memory write data.
REQ-011 SHALL have port cpu_reset_n, output, 1, the active-low reset driven to the processor core.
REQ-012 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-013 SHALL have port done, output, 1, meaning the last load completed with a good checksum.
REQ-014 SHALL have port error, output, 1, meaning the last load failed.

Function
REQ-015 SHALL implement the frame format: sync 0xA5, count low byte, count high byte, 4*count payload bytes, then 1 checksum byte.
REQ-016 SHALL treat each payload word as little-endian: byte0 goes to bits 7:0 and byte3 to bits 31:24.
REQ-017 SHALL define the checksum as the XOR of all payload bytes only, excluding the sync and count bytes.
REQ-018 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERROR.
REQ-019 SHALL, in IDLE/DONE/ERROR, go to LEN_LO on an accepted 0xA5 byte and ignore any other byte.
REQ-020 SHALL, on the LEN_LO and LEN_HI bytes, latch the 16-bit count.
REQ-021 SHALL, after LEN_HI, go to ERROR if count is 0 or greater than 2**ADDR_WIDTH, and otherwise go to DATA.
REQ-022 SHALL, in DATA, keep a 2-bit byte counter and a word counter starting at 0, and fold every payload byte into the running checksum.
REQ-023 SHALL, on acceptance of byte3 of a word, pulse imem_we for exactly the next cycle with imem_addr = word counter and imem_wdata = the assembled word.
REQ-024 SHALL go from DATA to CHECK when byte3 of word count-1 is accepted.
REQ-025 SHALL, in CHECK, compare the next accepted byte to the checksum and then go to DONE if equal, or ERROR if not.
REQ-026 SHALL hold rx_ready at 1 in every state except during reset, with no back-pressure, so one byte per cycle is sustained.
REQ-027 SHALL never let the word counter wrap: a count of 2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1 exactly once.
REQ-028 SHALL drive cpu_reset_n to 1 only in DONE and to 0 in every other state, including the first cycle of a new frame after DONE.
REQ-029 SHALL set busy=1 in LEN_LO, LEN_HI, DATA and CHECK; done=1 only in DONE; error=1 only in ERROR.
REQ-030 SHALL hold imem_addr and imem_wdata at their last values while imem_we=0.
REQ-031 SHALL stay in the current state on cycles without an accepted byte, with no timeout.
REQ-032 SHALL treat 0xA5 received inside LEN_LO/LEN_HI/DATA/CHECK as ordinary data and not as a resync.

Reset
REQ-033 SHALL, while reset_n=0 at a clock edge, force state IDLE, clear the counters and checksum, and set imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, busy=0, done=0, error=0 and rx_ready=0.
REQ-034 SHALL abort a load on reset mid-frame with no further imem_we pulses; words already written stay in memory.

Verification
REQ-035 SHALL cover a good load: A5 02 00 78 56 34 12 EF BE AD DE 2A -> writes addr0=0x12345678 and addr1=0xDEADBEEF, then done=1 and cpu_reset_n=1 one cycle after 0x2A is accepted.
REQ-036 SHALL cover a bad checksum: the same frame ending in 0x2B -> two writes occur, then error=1 and cpu_reset_n stays 0.
REQ-037 SHALL cover bad counts: A5 00 00 -> ERROR with no write; A5 01 04 (count 1025) -> ERROR with no write.
REQ-038 SHALL cover a gapped stream: the frame from REQ-035 with rx_valid=0 for 3 cycles between every byte -> identical writes and final state.
REQ-039 SHALL cover a reload: after DONE, send A5 -> cpu_reset_n=0 the next cycle and busy=1; then a 1-word frame 01 00 13 00 00 00 13 -> addr0=0x00000013 and DONE.
REQ-040 SHALL cover reset mid-frame: reset_n=0 for 1 cycle after payload byte 5 -> IDLE, no further writes, all outputs at their reset values.

Source files
------------

// File: rtl/imem_loader.sv
// Serial-link boot loader: parses A5/count/payload/checksum frames
// and writes 32-bit words into instruction memory.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   rx_valid, rx_data   incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready
//   imem_we/addr/wdata  instruction memory write port
//   cpu_reset_n         core reset, released only after a good load
//   busy, done, error   load status
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic                    rdy_q;
  logic [15:0]             cnt_q, cnt_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0]   word_q, word_d;
  logic [7:0]              chk_q, chk_d;
  logic [DATA_WIDTH-9:0]   buf_q, buf_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic        acc;
  logic [15:0] len_w;
  logic        last_w;

  assign acc   = rx_valid & rdy_q;
  assign len_w = {rx_data, cnt_q[7:0]};
  // Final word reached; comparison is widened so no counter wrap occurs.
  assign last_w = (17'(word_q) == (17'(cnt_q) - 17'd1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      chk_q   <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      chk_q   <= chk_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    chk_d   = chk_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (acc && rx_data == 8'hA5) begin
          state_d = LEN_LO;
          bcnt_d  = '0;
          word_d  = '0;
          chk_d   = '0;
        end
      end
      LEN_LO: begin
        if (acc) begin
          cnt_d   = {cnt_q[15:8], rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          cnt_d = len_w;
          if (len_w == 16'd0 || 17'(len_w) > MAX_WORDS)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
          chk_d  = chk_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          unique case (bcnt_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            2'd3: begin
              we_d    = 1'b1;
              addr_d  = word_q;
              wdata_d = {rx_data, buf_q};
              if (last_w)
                state_d = CHECK;
              else
                word_d = word_q + 1'b1;
            end
            default: ;
          endcase
        end
      end
      CHECK: begin
        if (acc)
          state_d = (rx_data == chk_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_ready    = rdy_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = (state_q == DONE);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);
  assign busy        = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: good/bad frames, bad counts,
// gapped stream, reload, full-size load and mid-frame reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  bit          seen [1024];
  int          wr_cnt = 0;
  bit          dup = 1'b0;
  logic [7:0]  fr [$];

  imem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (seen[imem_addr]) dup = 1'b1;
      seen[imem_addr] = 1'b1;
      mem[imem_addr]  = imem_wdata;
      wr_cnt          = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk);
    #1;
    wr_cnt = 0;
    dup    = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      seen[i] = 1'b0;
      mem[i]  = 32'hxxxx_xxxx;
    end
  endtask

  task automatic send_q(input int gap);
    foreach (fr[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = fr[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
  endtask

  task automatic endf();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rx_ready"}, rx_ready, 0);
    chk({tag, ".we"}, imem_we, 0);
    chk({tag, ".addr"}, imem_addr, 0);
    chk({tag, ".wdata"}, imem_wdata, 0);
    chk({tag, ".cpu_rst_n"}, cpu_reset_n, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  ck;

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", rx_ready, 1);

    // good load
    clr();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_q(0);
    endf();
    chk("good.done", done, 1);
    chk("good.cpu_rst_n", cpu_reset_n, 1);
    chk("good.busy", busy, 0);
    chk("good.error", error, 0);
    @(negedge clk);
    chk("good.wr_cnt", wr_cnt, 2);
    chk("good.mem0", mem[0], 32'h12345678);
    chk("good.mem1", mem[1], 32'hDEADBEEF);
    chk("good.addr_hold", imem_addr, 1);
    chk("good.wdata_hold", imem_wdata, 32'hDEADBEEF);
    chk("good.we_low", imem_we, 0);

    // bad checksum
    clr();
    fr[11] = 8'h2B;
    send_q(0);
    endf();
    @(negedge clk);
    chk("badck.wr_cnt", wr_cnt, 2);
    chk("badck.mem1", mem[1], 32'hDEADBEEF);
    chk("badck.error", error, 1);
    chk("badck.done", done, 0);
    chk("badck.cpu_rst_n", cpu_reset_n, 0);

    // count zero
    clr();
    fr = '{8'hA5, 8'h00, 8'h00};
    send_q(0);
    endf();
    repeat (2) @(negedge clk);
    chk("cnt0.error", error, 1);
    chk("cnt0.wr_cnt", wr_cnt, 0);

    // count 1025
    fr = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(0);
    endf();
    repeat (2) @(negedge clk);
    chk("cnt1025.error", error, 1);
    chk("cnt1025.busy", busy, 0);
    chk("cnt1025.wr_cnt", wr_cnt, 0);

    // gapped stream
    clr();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_q(3);
    endf();
    chk("gap.done", done, 1);
    chk("gap.cpu_rst_n", cpu_reset_n, 1);
    chk("gap.wr_cnt", wr_cnt, 2);
    chk("gap.mem0", mem[0], 32'h12345678);
    chk("gap.mem1", mem[1], 32'hDEADBEEF);

    // reload after DONE
    clr();
    fr = '{8'hA5};
    send_q(0);
    endf();
    chk("reload.cpu_rst_n", cpu_reset_n, 0);
    chk("reload.busy", busy, 1);
    chk("reload.done", done, 0);
    fr = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_q(0);
    endf();
    chk("reload.done2", done, 1);
    chk("reload.wr_cnt", wr_cnt, 1);
    chk("reload.mem0", mem[0], 32'h00000013);

    // full 1024-word load, 0xA5 bytes inside payload
    clr();
    fr = '{8'hA5, 8'h00, 8'h04};
    ck = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      w = {8'(i) ^ 8'h5A, 8'(i >> 8), 8'hA5, 8'(i)};
      fr.push_back(w[7:0]);
      fr.push_back(w[15:8]);
      fr.push_back(w[23:16]);
      fr.push_back(w[31:24]);
      ck = ck ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    fr.push_back(ck);
    send_q(0);
    endf();
    chk("full.done", done, 1);
    @(negedge clk);
    chk("full.wr_cnt", wr_cnt, 1024);
    chk("full.dup", dup, 0);
    chk("full.mem0", mem[0], 32'h5A00A500);
    chk("full.mem513", mem[513], 32'h5B02A501);
    chk("full.mem1023", mem[1023], 32'hA503A5FF);
    chk("full.addr", imem_addr, 1023);

    // reset mid-frame
    clr();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    send_q(0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    fr = '{8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_q(0);
    endf();
    repeat (2) @(negedge clk);
    chk("midrst.wr_cnt", wr_cnt, 1);
    chk("midrst.mem0", mem[0], 32'h12345678);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.error", error, 0);
    chk("midrst.addr", imem_addr, 0);
    chk("midrst.wdata", imem_wdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
